// File: rtl/cpu_types_pkg.sv
// Shared datapath types: forward-select sizing and the in-flight write scoreboard entry.
// Entry register-select field is sized for the widest register file in use; narrower files zero-extend.
package cpu_types_pkg;

  localparam int REG_W_MAX = 8;
  localparam int SB_RDY_W  = 4;

  function automatic int fwd_sel_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction

  localparam int FWD_SEL_W = fwd_sel_width(3);
  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic [REG_W_MAX-1:0] wsel;
    logic [SB_RDY_W-1:0]  rdy;
  } sb_entry_t;

endpackage

// File: rtl/forward_scoreboard_if.sv
// Signal bundle for forward_scoreboard; fsb is the unit's view, tb the driver's view.
// Purely structural, no timing of its own.
interface forward_scoreboard_if #(
  parameter int NSRC  = 2,
  parameter int REG_W = 5,
  parameter int SEL_W = 2,
  parameter int CNT_W = 32
) (
  input logic CLK
);
  logic                    RST;
  logic                    advance;
  logic                    flush;
  logic                    issue_valid;
  logic                    issue_wen;
  logic                    issue_load;
  logic [REG_W-1:0]        issue_wsel;
  logic [NSRC*REG_W-1:0]   src_sel;
  logic [NSRC-1:0]         src_used;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic                    stall;
  logic [CNT_W-1:0]        stall_cnt;

  modport fsb (
    input  CLK, RST, advance, flush, issue_valid, issue_wen, issue_load,
           issue_wsel, src_sel, src_used,
    output fwd_sel, stall, stall_cnt
  );

  modport tb (
    input  CLK, fwd_sel, stall, stall_cnt,
    output RST, advance, flush, issue_valid, issue_wen, issue_load,
           issue_wsel, src_sel, src_used
  );
endinterface

// File: rtl/fwd_match.sv
// Youngest-match priority encoder for one source operand against all scoreboard stages.
// Purely combinational; blocked means the youngest writer's result is not yet forwardable.
module fwd_match
  import cpu_types_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int REG_W   = 5,
  parameter int SEL_W   = 2
) (
  input  sb_entry_t [NSTAGES-1:0] entries,
  input  logic [REG_W-1:0]        src,
  input  logic                    used,
  output logic                    hit,
  output logic [SEL_W-1:0]        stage,
  output logic                    blocked
);
  logic [REG_W_MAX-1:0] src_ext;

  assign src_ext = REG_W_MAX'(src);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    blocked = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (used && entries[k].valid && entries[k].wen &&
          entries[k].wsel == src_ext && src_ext != '0) begin
        hit     = 1'b1;
        stage   = SEL_W'(k);
        blocked = SB_RDY_W'(k) < entries[k].rdy;
      end
    end
  end
endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding/hazard unit: shift register of in-flight writes, per-operand forward select, stall, stall counter.
// fwd_sel/stall are same-cycle combinational; state moves only when advance is high.
module forward_scoreboard
  import cpu_types_pkg::*;
#(
  parameter  int NSTAGES    = 3,
  parameter  int NSRC       = 2,
  parameter  int REG_W      = 5,
  parameter  int ALU_READY  = 1,
  parameter  int LOAD_READY = 2,
  parameter  int CNT_W      = 32,
  localparam int SEL_W      = $clog2(NSTAGES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic                  issue_load,
  input  logic [REG_W-1:0]      issue_wsel,
  input  logic [NSRC*REG_W-1:0] src_sel,
  input  logic [NSRC-1:0]       src_used,
  output logic [NSRC*SEL_W-1:0] fwd_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);
  sb_entry_t [NSTAGES-1:0] entries;
  sb_entry_t               new_entry;
  logic [NSRC-1:0]         hit;
  logic [NSRC-1:0]         blocked;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [SEL_W-1:0] stage;

    fwd_match #(
      .NSTAGES(NSTAGES),
      .REG_W  (REG_W),
      .SEL_W  (SEL_W)
    ) u_match (
      .entries(entries),
      .src    (src_sel[i*REG_W +: REG_W]),
      .used   (src_used[i]),
      .hit    (hit[i]),
      .stage  (stage),
      .blocked(blocked[i])
    );

    assign fwd_sel[i*SEL_W +: SEL_W] = (hit[i] && !blocked[i]) ? stage + SEL_W'(1) : '0;
  end

  assign stall = issue_valid && !flush && (|blocked);

  // A flushed or stalled decode slot becomes a bubble in EX.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = issue_valid && !flush && !stall;
    new_entry.wen   = issue_wen;
    new_entry.wsel  = REG_W_MAX'(issue_wsel);
    new_entry.rdy   = issue_load ? SB_RDY_W'(LOAD_READY) : SB_RDY_W'(ALU_READY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      entries   <= '0;
      stall_cnt <= '0;
    end else if (advance) begin
      for (int k = NSTAGES - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[0] <= new_entry;
      if (stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard: default build driven via the interface, plus a 4-stage/3-operand build.
// Expectations are pushed as each cycle is driven and popped/compared mid-cycle.
module tb_forward_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  forward_scoreboard_if #(.NSRC(2), .REG_W(5), .SEL_W(2), .CNT_W(32)) bus (.CLK(clk));

  forward_scoreboard dut (
    .CLK        (clk),
    .RST        (bus.RST),
    .advance    (bus.advance),
    .flush      (bus.flush),
    .issue_valid(bus.issue_valid),
    .issue_wen  (bus.issue_wen),
    .issue_load (bus.issue_load),
    .issue_wsel (bus.issue_wsel),
    .src_sel    (bus.src_sel),
    .src_used   (bus.src_used),
    .fwd_sel    (bus.fwd_sel),
    .stall      (bus.stall),
    .stall_cnt  (bus.stall_cnt)
  );

  logic        p_rst, p_adv, p_flush, p_iv, p_wen, p_ld;
  logic [4:0]  p_wsel;
  logic [14:0] p_src;
  logic [2:0]  p_used;
  logic [8:0]  p_fwd;
  logic        p_stall;
  logic [1:0]  p_cnt;

  forward_scoreboard #(.NSTAGES(4), .NSRC(3), .LOAD_READY(3), .CNT_W(2)) dut_p (
    .CLK        (clk),
    .RST        (p_rst),
    .advance    (p_adv),
    .flush      (p_flush),
    .issue_valid(p_iv),
    .issue_wen  (p_wen),
    .issue_load (p_ld),
    .issue_wsel (p_wsel),
    .src_sel    (p_src),
    .src_used   (p_used),
    .fwd_sel    (p_fwd),
    .stall      (p_stall),
    .stall_cnt  (p_cnt)
  );

  typedef struct {
    string       tag;
    bit          par;
    logic [31:0] fwd;
    logic        stl;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.par) begin
        check({e.tag, "/fwd"},   32'(p_fwd),   e.fwd);
        check({e.tag, "/stall"}, 32'(p_stall), 32'(e.stl));
        check({e.tag, "/cnt"},   32'(p_cnt),   e.cnt);
      end else begin
        check({e.tag, "/fwd"},   32'(bus.fwd_sel),   e.fwd);
        check({e.tag, "/stall"}, 32'(bus.stall),     32'(e.stl));
        check({e.tag, "/cnt"},   32'(bus.stall_cnt), e.cnt);
      end
    end
  endtask

  // One cycle on the default build: drive, queue expectation, compare mid-cycle, then let the edge commit.
  task automatic dcyc(input string tag, input logic r, adv, fl, iv, wen, ld,
                      input logic [4:0] ws, a, b, input logic [1:0] u,
                      input logic [3:0] ef, input logic es, input logic [31:0] ec);
    bus.RST = r;  bus.advance = adv;  bus.flush = fl;
    bus.issue_valid = iv;  bus.issue_wen = wen;  bus.issue_load = ld;
    bus.issue_wsel = ws;  bus.src_sel = {b, a};  bus.src_used = u;
    q.push_back('{tag, 1'b0, 32'(ef), es, ec});
    #3;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic pcyc(input string tag, input logic iv, wen, ld,
                      input logic [4:0] ws, a, input logic [2:0] u,
                      input logic [8:0] ef, input logic es, input logic [1:0] ec);
    p_iv = iv;  p_wen = wen;  p_ld = ld;  p_wsel = ws;
    p_src = {a, a, a};  p_used = u;
    q.push_back('{tag, 1'b1, 32'(ef), es, 32'(ec)});
    #3;
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.RST = 1'b1;  bus.advance = 1'b1;  bus.flush = 1'b0;
    bus.issue_valid = 1'b0;  bus.issue_wen = 1'b0;  bus.issue_load = 1'b0;
    bus.issue_wsel = '0;  bus.src_sel = '0;  bus.src_used = '0;
    p_rst = 1'b1;  p_adv = 1'b1;  p_flush = 1'b0;  p_iv = 1'b0;  p_wen = 1'b0;
    p_ld = 1'b0;  p_wsel = '0;  p_src = '0;  p_used = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.RST = 1'b0;
    p_rst = 1'b0;

    //    tag          rst adv fl iv we ld  ws  a   b   used   fwd  stl cnt
    dcyc("reset",      0,  1,  0, 0, 0, 0,  0,  0,  0, 2'b11, 4'h0, 0, 0);
    dcyc("lw_r5",      0,  1,  0, 1, 1, 1,  5,  0,  0, 2'b00, 4'h0, 0, 0);
    dcyc("lu_stall1",  0,  1,  0, 1, 1, 0,  6,  5,  5, 2'b11, 4'h0, 1, 0);
    dcyc("lu_stall2",  0,  1,  0, 1, 1, 0,  6,  5,  5, 2'b11, 4'h0, 1, 1);
    dcyc("lu_fwd",     0,  1,  0, 1, 1, 0,  6,  5,  5, 2'b11, 4'hF, 0, 2);
    dcyc("window",     0,  1,  0, 0, 0, 0,  0,  5,  6, 2'b11, 4'h0, 0, 2);
    dcyc("alu_r3",     0,  1,  0, 1, 1, 0,  3,  0,  0, 2'b00, 4'h0, 0, 2);
    dcyc("alu_stall",  0,  1,  0, 1, 1, 0,  7,  3,  0, 2'b01, 4'h0, 1, 2);
    dcyc("alu_fwd2",   0,  1,  0, 1, 1, 0,  7,  3,  0, 2'b01, 4'h2, 0, 3);
    dcyc("alu_fwd3",   0,  1,  0, 1, 1, 0,  9,  3,  0, 2'b01, 4'h3, 0, 3);
    dcyc("r4_a",       0,  1,  0, 1, 1, 0,  4,  0,  0, 2'b00, 4'h0, 0, 3);
    dcyc("r4_b",       0,  1,  0, 1, 1, 0,  4,  0,  0, 2'b00, 4'h0, 0, 3);
    dcyc("no_write",   0,  1,  0, 1, 0, 0,  0,  0,  0, 2'b00, 4'h0, 0, 3);
    dcyc("youngest",   0,  1,  0, 1, 0, 0,  0,  4,  4, 2'b11, 4'hA, 0, 3);
    dcyc("r0_write",   0,  1,  0, 1, 1, 0,  0,  0,  0, 2'b00, 4'h0, 0, 3);
    dcyc("r0_k0",      0,  1,  0, 1, 0, 0,  0,  0,  0, 2'b11, 4'h0, 0, 3);
    dcyc("r0_k1",      0,  1,  0, 1, 0, 0,  0,  0,  0, 2'b11, 4'h0, 0, 3);
    dcyc("lw_r10",     0,  1,  0, 1, 1, 1, 10,  0,  0, 2'b00, 4'h0, 0, 3);
    dcyc("flush",      0,  1,  1, 1, 1, 0, 11, 10,  0, 2'b01, 4'h0, 0, 3);
    dcyc("bubble",     0,  1,  0, 1, 0, 0,  0, 11,  0, 2'b01, 4'h0, 0, 3);
    dcyc("lw_r12",     0,  1,  0, 1, 1, 1, 12,  0,  0, 2'b00, 4'h0, 0, 3);
    for (int i = 0; i < 5; i++)
      dcyc("hold",     0,  0,  0, 1, 1, 0, 13, 12,  0, 2'b01, 4'h0, 1, 3);
    dcyc("hold_end",   0,  1,  0, 1, 1, 0, 13, 12,  0, 2'b01, 4'h0, 1, 3);
    dcyc("lu2_stall",  0,  1,  0, 1, 1, 0, 13, 12,  0, 2'b01, 4'h0, 1, 4);
    dcyc("lu2_fwd",    0,  1,  0, 1, 1, 0, 13, 12,  0, 2'b01, 4'h3, 0, 5);
    dcyc("lw_r8",      0,  1,  0, 1, 1, 1,  8,  0,  0, 2'b00, 4'h0, 0, 5);
    dcyc("rst_mid",    1,  0,  0, 1, 1, 0, 14,  8,  0, 2'b01, 4'h0, 1, 5);
    dcyc("post_rst",   0,  1,  0, 1, 1, 0, 14,  8,  0, 2'b01, 4'h0, 0, 0);

    //    tag         iv we ld  ws  a  used    fwd     stl cnt
    pcyc("p_idle",    0, 0, 0,  0,  0, 3'b000, 9'h000, 0, 0);
    pcyc("p_lw",      1, 1, 1,  5,  0, 3'b000, 9'h000, 0, 0);
    pcyc("p_stall1",  1, 1, 0,  6,  5, 3'b111, 9'h000, 1, 0);
    pcyc("p_stall2",  1, 1, 0,  6,  5, 3'b111, 9'h000, 1, 1);
    pcyc("p_stall3",  1, 1, 0,  6,  5, 3'b111, 9'h000, 1, 2);
    pcyc("p_fwd",     1, 1, 0,  6,  5, 3'b111, 9'h124, 0, 3);
    pcyc("p_sat",     1, 0, 0,  0,  6, 3'b001, 9'h000, 1, 3);
    pcyc("p_sat_hold",1, 0, 0,  0,  6, 3'b001, 9'h002, 0, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
